// File: rtl/avr_io_core_regs_pkg.sv
// Shared definitions for the core-resident AVR I/O registers.
// Holds the I/O addresses of the stack pointer, status, RAMPZ and EIND
// registers and the SREG bit positions. The I/O read multiplexer uses the
// same constants, so both sides agree on the register map.
package avr_io_core_regs_pkg;

  // I/O space addresses (6-bit, as seen on adr)
  localparam logic [5:0] ADR_RAMPZ = 6'h3B;
  localparam logic [5:0] ADR_EIND  = 6'h3C;
  localparam logic [5:0] ADR_SPL   = 6'h3D;
  localparam logic [5:0] ADR_SPH   = 6'h3E;
  localparam logic [5:0] ADR_SREG  = 6'h3F;

  // SREG bit positions
  localparam int SREG_C = 0;
  localparam int SREG_Z = 1;
  localparam int SREG_N = 2;
  localparam int SREG_V = 3;
  localparam int SREG_S = 4;
  localparam int SREG_H = 5;
  localparam int SREG_T = 6;
  localparam int SREG_I = 7;

endpackage

// File: rtl/avr_io_core_regs_sp_cnt.sv
// avr_sp_cnt: WIDTH-bit stack-pointer up/down counter with byte-wise
// parallel load. A load of either byte takes priority over a step, and the
// step is then dropped for both bytes.
// Ports:
//   clk_i    core clock, rising edge
//   rst_ni   asynchronous active-low reset
//   en_i     clock enable, nothing changes when 0
//   ld_lo_i  load low byte from din_i
//   ld_hi_i  load high byte from din_i (bits above WIDTH discarded)
//   din_i    load data
//   step_i   step request
//   up_i     1 = increment, 0 = decrement
//   cnt_o    counter value, zero-extended to 16 bits
module avr_sp_cnt #(
  parameter int          WIDTH     = 16,
  parameter logic [15:0] RESET_VAL = 16'h0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        en_i,
  input  logic        ld_lo_i,
  input  logic        ld_hi_i,
  input  logic [7:0]  din_i,
  input  logic        step_i,
  input  logic        up_i,
  output logic [15:0] cnt_o
);

  localparam logic [WIDTH-1:0] RST_V = RESET_VAL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] ONE   = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (ld_lo_i || ld_hi_i) begin
      if (ld_lo_i) cnt_d[7:0] = din_i;
      if (ld_hi_i) cnt_d[WIDTH-1:8] = din_i[WIDTH-9:0];
    end else if (step_i) begin
      // Full-width add/subtract: carry and borrow cross the byte boundary
      // and wrap modulo 2^WIDTH.
      cnt_d = up_i ? (cnt_q + ONE) : (cnt_q - ONE);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)   cnt_q <= RST_V;
    else if (en_i) cnt_q <= cnt_d;
  end

  assign cnt_o = 16'(cnt_q);

endmodule

// File: rtl/avr_io_core_regs.sv
// avr_io_core_regs: core-resident I/O registers of the AVR core
// (SPL, SPH, SREG, RAMPZ and optionally EIND).
// All outputs come straight from flops.
// Ports:
//   cp2          core clock, rising edge
//   ireset       asynchronous active-low reset
//   cp2en        clock enable, freezes all state when 0
//   adr/iowe/dbusout  I/O write address, strobe and data
//   sreg_fl_in/sreg_fl_wr  ALU flag values and per-bit update enables
//   irq_ack      interrupt accepted, clears I
//   reti_st      RETI executing, sets I
//   sp_en/sp_ndown_up  stack-pointer step request and direction (1 = up)
//   spl_out/sph_out/sreg_out/rampz_out/eind_out  register values
//   sp_out       {sph_out, spl_out}
module avr_io_core_regs
  import avr_io_core_regs_pkg::*;
#(
  parameter int          pc22b       = 0,
  parameter int          SP_WIDTH    = 16,
  parameter logic [15:0] SP_RESET    = 16'h0000,
  parameter int          RAMPZ_WIDTH = 1
) (
  input  logic        cp2,
  input  logic        ireset,
  input  logic        cp2en,
  input  logic [5:0]  adr,
  input  logic        iowe,
  input  logic [7:0]  dbusout,
  input  logic [7:0]  sreg_fl_in,
  input  logic [7:0]  sreg_fl_wr,
  input  logic        irq_ack,
  input  logic        reti_st,
  input  logic        sp_en,
  input  logic        sp_ndown_up,
  output logic [7:0]  spl_out,
  output logic [7:0]  sph_out,
  output logic [7:0]  sreg_out,
  output logic [7:0]  rampz_out,
  output logic [7:0]  eind_out,
  output logic [15:0] sp_out
);

  logic wr_spl, wr_sph, wr_sreg, wr_rampz;

  assign wr_spl   = iowe && (adr == ADR_SPL);
  assign wr_sph   = iowe && (adr == ADR_SPH);
  assign wr_sreg  = iowe && (adr == ADR_SREG);
  assign wr_rampz = iowe && (adr == ADR_RAMPZ);

  // Stack pointer
  logic [15:0] sp_q;

  avr_sp_cnt #(
    .WIDTH     (SP_WIDTH),
    .RESET_VAL (SP_RESET)
  ) u_sp_cnt (
    .clk_i   (cp2),
    .rst_ni  (ireset),
    .en_i    (cp2en),
    .ld_lo_i (wr_spl),
    .ld_hi_i (wr_sph),
    .din_i   (dbusout),
    .step_i  (sp_en),
    .up_i    (sp_ndown_up),
    .cnt_o   (sp_q)
  );

  assign sp_out  = sp_q;
  assign spl_out = sp_q[7:0];
  assign sph_out = sp_q[15:8];

  // SREG
  logic [7:0] sreg_q, sreg_d;

  always_comb begin
    sreg_d = sreg_q;
    if (wr_sreg) begin
      sreg_d = dbusout;
    end else begin
      for (int n = 0; n < SREG_I; n++) begin
        if (sreg_fl_wr[n]) sreg_d[n] = sreg_fl_in[n];
      end
      // Interrupt acceptance must win over a simultaneous RETI or BSET so
      // that I is never left set while entering a handler.
      if (irq_ack)                 sreg_d[SREG_I] = 1'b0;
      else if (reti_st)            sreg_d[SREG_I] = 1'b1;
      else if (sreg_fl_wr[SREG_I]) sreg_d[SREG_I] = sreg_fl_in[SREG_I];
    end
  end

  always_ff @(posedge cp2 or negedge ireset) begin
    if (!ireset)    sreg_q <= 8'h00;
    else if (cp2en) sreg_q <= sreg_d;
  end

  assign sreg_out = sreg_q;

  // RAMPZ: only RAMPZ_WIDTH bits are stored
  logic [RAMPZ_WIDTH-1:0] rampz_q, rampz_d;

  assign rampz_d = wr_rampz ? dbusout[RAMPZ_WIDTH-1:0] : rampz_q;

  always_ff @(posedge cp2 or negedge ireset) begin
    if (!ireset)    rampz_q <= '0;
    else if (cp2en) rampz_q <= rampz_d;
  end

  assign rampz_out = 8'(rampz_q);

  // EIND exists only on 22-bit PC cores
  if (pc22b != 0) begin : g_eind
    logic       wr_eind;
    logic [7:0] eind_q, eind_d;

    assign wr_eind = iowe && (adr == ADR_EIND);
    assign eind_d  = wr_eind ? dbusout : eind_q;

    always_ff @(posedge cp2 or negedge ireset) begin
      if (!ireset)    eind_q <= 8'h00;
      else if (cp2en) eind_q <= eind_d;
    end

    assign eind_out = eind_q;
  end else begin : g_no_eind
    assign eind_out = 8'h00;
  end

endmodule

// File: tb/tb_avr_io_core_regs.sv
// Bench for avr_io_core_regs. Two instances share all inputs:
//   dut_a: pc22b=1, SP_WIDTH=16, SP_RESET=16'h10FF
//   dut_b: pc22b=0, SP_WIDTH=12, SP_RESET=16'h10FF (resets to 16'h00FF)
module tb_avr_io_core_regs;

  logic        cp2 = 1'b0;
  logic        ireset = 1'b0;
  logic        cp2en = 1'b1;
  logic [5:0]  adr = '0;
  logic        iowe = 1'b0;
  logic [7:0]  dbusout = '0;
  logic [7:0]  sreg_fl_in = '0;
  logic [7:0]  sreg_fl_wr = '0;
  logic        irq_ack = 1'b0;
  logic        reti_st = 1'b0;
  logic        sp_en = 1'b0;
  logic        sp_ndown_up = 1'b0;

  logic [7:0]  a_spl, a_sph, a_sreg, a_rampz, a_eind;
  logic [15:0] a_sp;
  logic [7:0]  b_spl, b_sph, b_sreg, b_rampz, b_eind;
  logic [15:0] b_sp;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  always #5 cp2 = ~cp2;

  avr_io_core_regs #(
    .pc22b(1), .SP_WIDTH(16), .SP_RESET(16'h10FF), .RAMPZ_WIDTH(1)
  ) dut_a (
    .cp2(cp2), .ireset(ireset), .cp2en(cp2en), .adr(adr), .iowe(iowe),
    .dbusout(dbusout), .sreg_fl_in(sreg_fl_in), .sreg_fl_wr(sreg_fl_wr),
    .irq_ack(irq_ack), .reti_st(reti_st), .sp_en(sp_en),
    .sp_ndown_up(sp_ndown_up), .spl_out(a_spl), .sph_out(a_sph),
    .sreg_out(a_sreg), .rampz_out(a_rampz), .eind_out(a_eind), .sp_out(a_sp)
  );

  avr_io_core_regs #(
    .pc22b(0), .SP_WIDTH(12), .SP_RESET(16'h10FF), .RAMPZ_WIDTH(1)
  ) dut_b (
    .cp2(cp2), .ireset(ireset), .cp2en(cp2en), .adr(adr), .iowe(iowe),
    .dbusout(dbusout), .sreg_fl_in(sreg_fl_in), .sreg_fl_wr(sreg_fl_wr),
    .irq_ack(irq_ack), .reti_st(reti_st), .sp_en(sp_en),
    .sp_ndown_up(sp_ndown_up), .spl_out(b_spl), .sph_out(b_sph),
    .sreg_out(b_sreg), .rampz_out(b_rampz), .eind_out(b_eind), .sp_out(b_sp)
  );

  // Apply current inputs for one edge, sample 1 time unit after it,
  // then return inputs to idle.
  task automatic tick();
    @(posedge cp2);
    #1;
    iowe = 1'b0; sp_en = 1'b0; sreg_fl_wr = 8'h00; sreg_fl_in = 8'h00;
    irq_ack = 1'b0; reti_st = 1'b0; adr = 6'h00; dbusout = 8'h00;
  endtask

  task automatic io_wr(input logic [5:0] a, input logic [7:0] d);
    adr = a; dbusout = d; iowe = 1'b1;
    tick();
  endtask

  task automatic sp_step(input logic up);
    sp_en = 1'b1; sp_ndown_up = up;
    tick();
  endtask

  task automatic test_reset();
    ireset = 1'b0;
    repeat (2) @(posedge cp2);
    #1 ireset = 1'b1;
    tot_cnt++; if (a_sp !== 16'h10FF) $display("FAIL rst_a_sp got %h exp %h", a_sp, 16'h10FF); else pass_cnt++;
    tot_cnt++; if (b_sp !== 16'h00FF) $display("FAIL rst_b_sp got %h exp %h", b_sp, 16'h00FF); else pass_cnt++;
    tot_cnt++; if ({a_sreg, a_rampz, a_eind} !== 24'h0) $display("FAIL rst_a_regs got %h exp 000000", {a_sreg, a_rampz, a_eind}); else pass_cnt++;
    tot_cnt++; if ({b_sreg, b_rampz, b_eind} !== 24'h0) $display("FAIL rst_b_regs got %h exp 000000", {b_sreg, b_rampz, b_eind}); else pass_cnt++;
    tot_cnt++; if ({a_sph, a_spl} !== 16'h10FF) $display("FAIL rst_a_bytes got %h exp 10ff", {a_sph, a_spl}); else pass_cnt++;
  endtask

  task automatic test_sp_wrap();
    logic [15:0] exp_a [3];
    logic [15:0] exp_b [3];
    exp_a = '{16'hFFFF, 16'hFFFE, 16'hFFFD};
    exp_b = '{16'h0FFF, 16'h0FFE, 16'h0FFD};
    io_wr(6'h3D, 8'h00);
    io_wr(6'h3E, 8'h00);
    tot_cnt++; if (a_sp !== 16'h0000) $display("FAIL wr_sp0_a got %h exp 0000", a_sp); else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      sp_step(1'b0);
      tot_cnt++; if (a_sp !== exp_a[i]) $display("FAIL dec_a%0d got %h exp %h", i, a_sp, exp_a[i]); else pass_cnt++;
      tot_cnt++; if (b_sp !== exp_b[i]) $display("FAIL dec_b%0d got %h exp %h", i, b_sp, exp_b[i]); else pass_cnt++;
    end
    io_wr(6'h3D, 8'hFF);
    io_wr(6'h3E, 8'hFF);
    tot_cnt++; if (a_sp !== 16'hFFFF) $display("FAIL wr_spff_a got %h exp ffff", a_sp); else pass_cnt++;
    tot_cnt++; if (b_sp !== 16'h0FFF) $display("FAIL wr_sph_mask_b got %h exp 0fff", b_sp); else pass_cnt++;
    sp_step(1'b1);
    tot_cnt++; if (a_sp !== 16'h0000) $display("FAIL inc_wrap_a got %h exp 0000", a_sp); else pass_cnt++;
    tot_cnt++; if (b_sp !== 16'h0000) $display("FAIL inc_wrap_b got %h exp 0000", b_sp); else pass_cnt++;
    // carry across the byte boundary: 00FF + 1 = 0100
    io_wr(6'h3D, 8'hFF);
    sp_step(1'b1);
    tot_cnt++; if (a_sp !== 16'h0100) $display("FAIL inc_carry_a got %h exp 0100", a_sp); else pass_cnt++;
  endtask

  task automatic test_collision();
    io_wr(6'h3D, 8'h10);
    io_wr(6'h3E, 8'h02);
    adr = 6'h3D; dbusout = 8'h80; iowe = 1'b1; sp_en = 1'b1; sp_ndown_up = 1'b0;
    tick();
    tot_cnt++; if (a_sp !== 16'h0280) $display("FAIL coll_spl_a got %h exp 0280", a_sp); else pass_cnt++;
    tot_cnt++; if (b_sp !== 16'h0280) $display("FAIL coll_spl_b got %h exp 0280", b_sp); else pass_cnt++;
    adr = 6'h3E; dbusout = 8'h05; iowe = 1'b1; sp_en = 1'b1; sp_ndown_up = 1'b1;
    tick();
    tot_cnt++; if (a_sp !== 16'h0580) $display("FAIL coll_sph_a got %h exp 0580", a_sp); else pass_cnt++;
  endtask

  task automatic test_sreg();
    sreg_fl_wr = 8'h03; sreg_fl_in = 8'hFF;
    tick();
    tot_cnt++; if (a_sreg !== 8'h03) $display("FAIL sreg_flags got %h exp 03", a_sreg); else pass_cnt++;
    reti_st = 1'b1;
    tick();
    tot_cnt++; if (a_sreg !== 8'h83) $display("FAIL sreg_reti got %h exp 83", a_sreg); else pass_cnt++;
    irq_ack = 1'b1; reti_st = 1'b1;
    tick();
    tot_cnt++; if (a_sreg !== 8'h03) $display("FAIL sreg_ack_vs_reti got %h exp 03", a_sreg); else pass_cnt++;
    adr = 6'h3F; dbusout = 8'h80; iowe = 1'b1; irq_ack = 1'b1;
    sreg_fl_wr = 8'h01; sreg_fl_in = 8'h01;
    tick();
    tot_cnt++; if (a_sreg !== 8'h80) $display("FAIL sreg_io_vs_ack got %h exp 80", a_sreg); else pass_cnt++;
    // ALU flags on bits 4..7 from 8'h5A clears I and sets S and T; low bits hold
    sreg_fl_wr = 8'hF0; sreg_fl_in = 8'h5A;
    tick();
    tot_cnt++; if (a_sreg !== 8'h50) $display("FAIL sreg_fl_hi got %h exp 50", a_sreg); else pass_cnt++;
  endtask

  task automatic test_ext_regs();
    io_wr(6'h3C, 8'h01);
    tot_cnt++; if (a_eind !== 8'h01) $display("FAIL eind_a got %h exp 01", a_eind); else pass_cnt++;
    tot_cnt++; if (b_eind !== 8'h00) $display("FAIL eind_b got %h exp 00", b_eind); else pass_cnt++;
    io_wr(6'h3B, 8'hFF);
    tot_cnt++; if (a_rampz !== 8'h01) $display("FAIL rampz_a got %h exp 01", a_rampz); else pass_cnt++;
    io_wr(6'h3A, 8'h77);
    tot_cnt++; if ({a_sp, a_sreg, a_rampz, a_eind} !== {16'h0580, 8'h50, 8'h01, 8'h01})
      $display("FAIL other_adr got %h exp 0580500101", {a_sp, a_sreg, a_rampz, a_eind}); else pass_cnt++;
  endtask

  task automatic test_freeze();
    cp2en = 1'b0;
    adr = 6'h3D; dbusout = 8'hAA; iowe = 1'b1; sp_en = 1'b1; sp_ndown_up = 1'b0;
    sreg_fl_wr = 8'hFF; sreg_fl_in = 8'hFF; reti_st = 1'b1;
    tick();
    adr = 6'h3C; dbusout = 8'hEE; iowe = 1'b1;
    tick();
    cp2en = 1'b1;
    tot_cnt++; if (a_sp !== 16'h0580) $display("FAIL freeze_sp got %h exp 0580", a_sp); else pass_cnt++;
    tot_cnt++; if (a_sreg !== 8'h50) $display("FAIL freeze_sreg got %h exp 50", a_sreg); else pass_cnt++;
    tot_cnt++; if (a_eind !== 8'h01) $display("FAIL freeze_eind got %h exp 01", a_eind); else pass_cnt++;
  endtask

  task automatic test_reset_mid_push();
    sp_step(1'b0);
    tot_cnt++; if (a_sp !== 16'h057F) $display("FAIL push1_a got %h exp 057f", a_sp); else pass_cnt++;
    // assert reset between clock edges; it must act without an edge
    #2 ireset = 1'b0;
    #1;
    tot_cnt++; if (a_sp !== 16'h10FF) $display("FAIL async_rst_a got %h exp 10ff", a_sp); else pass_cnt++;
    tot_cnt++; if (b_sp !== 16'h00FF) $display("FAIL async_rst_b got %h exp 00ff", b_sp); else pass_cnt++;
    tot_cnt++; if ({a_sreg, a_rampz, a_eind} !== 24'h0) $display("FAIL async_rst_regs got %h exp 000000", {a_sreg, a_rampz, a_eind}); else pass_cnt++;
    @(posedge cp2);
    #1 ireset = 1'b1;
    sp_step(1'b0);
    tot_cnt++; if (a_sp !== 16'h10FE) $display("FAIL after_rst_dec got %h exp 10fe", a_sp); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_sp_wrap();
    test_collision();
    test_sreg();
    test_ext_regs();
    test_freeze();
    test_reset_mid_push();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule

// File: doc/avr_io_core_regs.md
# avr_io_core_regs

Holds the core-resident I/O registers of the AVR core: SPL, SPH, SREG, RAMPZ and, when enabled, EIND. Handles three kinds of update:
- I/O writes (OUT/STS to 0x3B..0x3F)
- stack-pointer increment/decrement for push/pop/call/ret sequences
- per-flag SREG updates from the ALU, plus I-flag control from the interrupt logic

Its registered outputs feed the I/O read multiplexer directly (spl_out, sph_out, sreg_out, rampz_out, eind_out) and the data-address path (sp_out).

## Interface
Parameters:
- pc22b, 0, nonzero implements EIND; when 0, EIND is not stored and eind_out is 8'h00
- SP_WIDTH, 16, implemented stack-pointer bits (9..16); unimplemented upper bits read 0 and are never written
- SP_RESET, 16'h0000, stack-pointer reset value (masked to SP_WIDTH)
- RAMPZ_WIDTH, 1, implemented RAMPZ bits (1..8); upper bits read 0

Ports:
- cp2  in  1  core clock, rising edge
- ireset  in  1  reset, asynchronous, active-low
- cp2en  in  1  clock enable; no state changes when 0
- adr  in  6  I/O address
- iowe  in  1  I/O write strobe
- dbusout  in  8  I/O write data
- sreg_fl_in  in  8  new SREG flag values from the ALU
- sreg_fl_wr  in  8  per-bit SREG update enables
- irq_ack  in  1  interrupt accepted; clears I
- reti_st  in  1  RETI executing; sets I
- sp_en  in  1  stack-pointer step request
- sp_ndown_up  in  1  1 = increment (pop/ret), 0 = decrement (push/call)
- spl_out, sph_out, sreg_out, rampz_out, eind_out  out  8 each  register values
- sp_out  out  16  {sph_out, spl_out}

## Operation
- All state updates occur on the rising edge of cp2 when cp2en = 1.
- Reset values:
  - SP = SP_RESET masked to SP_WIDTH
  - SREG = 8'h00
  - RAMPZ = 8'h00
  - EIND = 8'h00
- I/O writes take effect when iowe = 1 and adr matches:
  - 0x3D writes SPL
  - 0x3E writes SPH; bits at or above SP_WIDTH-8 are discarded
  - 0x3F writes SREG
  - 0x3B writes RAMPZ, masked to RAMPZ_WIDTH
  - 0x3C writes EIND, only when pc22b ≠ 0; otherwise ignored
  - All other addresses are ignored.
- Stack pointer: sp_en = 1 steps SP by ±1 modulo 2^SP_WIDTH.
  - Decrement from 0 wraps to 2^SP_WIDTH−1.
  - Increment from 2^SP_WIDTH−1 wraps to 0.
  - Carry/borrow propagates across SPL/SPH in the same cycle.
- SP priority: an I/O write to SPL or SPH in the same cycle as sp_en wins, and the step is dropped for both bytes. SPL gets dbusout and SPH is held, or vice versa.
- SREG bits 0..6:
  - An I/O write to SREG wins over the ALU path.
  - Otherwise each bit n with sreg_fl_wr[n] = 1 loads sreg_fl_in[n].
  - Bits with a zero enable hold.
- SREG bit 7 (I) priority, highest first:
  1. I/O write
  2. irq_ack (clear)
  3. reti_st (set)
  4. sreg_fl_wr[7] (BSET/BCLR)
  5. hold
- Reset asserted mid-sequence (e.g. between the two bytes of a call push) returns every register to its reset value immediately. No partial state survives.
- cp2en = 0 freezes all registers regardless of the other inputs.

## Timing
- Every update has one-cycle latency: a write or step sampled at edge k is visible on the outputs after edge k and is readable by the downstream mux in cycle k+1.
- Outputs come directly from flops, with no combinational path from inputs. sp_out is a pure concatenation of the flops.
- Back-to-back sp_en on consecutive enabled cycles steps once per cycle. A 2-byte push therefore completes in 2 cycles, and a 3-byte push (pc22b) in 3.
- ireset takes effect asynchronously. Its release is synchronised to cp2 by the reset generator upstream, so this block has no synchroniser.

## Structure
- Shared package holds:
  - address constants for SPL 0x3D, SPH 0x3E, SREG 0x3F, RAMPZ 0x3B, EIND 0x3C
  - SREG bit-index constants: C=0, Z=1, N=2, V=3, S=4, H=5, T=6, I=7

  The I/O read multiplexer uses the same constants.
- One sub-module, avr_sp_cnt: an SP_WIDTH-wide up/down counter with a parallel byte load and load-over-step priority.
- The EIND storage is a generate branch on pc22b.

## Test plan
- Reset, then check every output: reset with SP_RESET = 16'h10FF, SP_WIDTH = 12 → sp_out = 16'h00FF, sreg_out = 0, rampz_out = 0, eind_out = 0.
- Stack wrap:
  - SP = 0, three sp_en cycles with sp_ndown_up = 0 → SP = FFFF, FFFE, FFFD (SP_WIDTH = 16).
  - Then SP = FFFF, one increment → 0000.
- Write/step collision: iowe to 0x3D with dbusout = 8'h80, together with sp_en decrement, while SP = 16'h0210 → sp_out = 16'h0280.
- SREG flags and I priority:
  - sreg_fl_wr = 8'h03, sreg_fl_in = 8'hFF on SREG = 0 → sreg_out = 8'h03.
  - irq_ack and reti_st in the same cycle → I = 0.
  - iowe to 0x3F with 8'h80 together with irq_ack → I = 1.
- pc22b = 0 vs 1: write 8'h01 to 0x3C → eind_out = 8'h00 and 8'h01 respectively. Write 8'hFF to 0x3B with RAMPZ_WIDTH = 1 → rampz_out = 8'h01.
- Freeze and reset:
  - cp2en = 0 with iowe/sp_en active → no change.
  - Assert ireset between the two decrements of a call push → sp_out returns to SP_RESET immediately, without waiting for a clock edge.
